// File: rtl/sched_request_issuer.sv
// Request issuer between the host port and the DDR4 controller FSM: queues bursts and
// issues them one at a time with a start/done handshake, returning responses in order.
module sched_request_issuer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int BL      = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [BL*DATA_W-1:0] req_wdata,
  output logic                 start,
  output logic                 cmd_write,
  output logic [ADDR_W-1:0]    cmd_addr,
  output logic [BL*DATA_W-1:0] cmd_wdata,
  input  logic                 done,
  input  logic [BL*DATA_W-1:0] ctl_rdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_write,
  output logic [BL*DATA_W-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 err_sticky
);

  // state | meaning
  // IDLE  | waiting for a queued request; pops head into cmd_* and pulses start
  // ISSUE | start pulse cycle; clears timer
  // WAIT  | waiting for done or timeout
  // RESP  | holding response until host accepts
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = BL * DATA_W;
  localparam int EW = 1 + ADDR_W + WW;

  state_t              state, state_nxt;
  logic [EW-1:0]       mem [DEPTH];
  logic [PW:0]         wr_ptr, rd_ptr;
  logic                ready_en;
  logic                full, empty, push, pop;
  logic [TW-1:0]       timer, timer_nxt;
  logic                start_nxt, cmd_write_nxt;
  logic [ADDR_W-1:0]   cmd_addr_nxt;
  logic [WW-1:0]       cmd_wdata_nxt;
  logic                rsp_valid_nxt, rsp_write_nxt, rsp_err_nxt, err_sticky_nxt;
  logic [WW-1:0]       rsp_rdata_nxt;

  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign req_ready = ready_en && !full;
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && !empty;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[PW-1:0]] <= {req_write, req_addr, req_wdata};
  end

  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    start_nxt      = 1'b0;
    cmd_write_nxt  = cmd_write;
    cmd_addr_nxt   = cmd_addr;
    cmd_wdata_nxt  = cmd_wdata;
    rsp_valid_nxt  = rsp_valid;
    rsp_write_nxt  = rsp_write;
    rsp_rdata_nxt  = rsp_rdata;
    rsp_err_nxt    = rsp_err;
    err_sticky_nxt = err_sticky;
    case (state)
      IDLE: begin
        if (!empty) begin
          {cmd_write_nxt, cmd_addr_nxt, cmd_wdata_nxt} = mem[rd_ptr[PW-1:0]];
          start_nxt = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        timer_nxt = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // done takes priority over a timeout landing in the same cycle
        if (done) begin
          rsp_rdata_nxt = cmd_write ? '0 : ctl_rdata;
          rsp_write_nxt = cmd_write;
          rsp_err_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          rsp_rdata_nxt  = '0;
          rsp_write_nxt  = cmd_write;
          rsp_err_nxt    = 1'b1;
          err_sticky_nxt = 1'b1;
          rsp_valid_nxt  = 1'b1;
          state_nxt      = RESP;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ready_en   <= 1'b0;
      timer      <= '0;
      start      <= 1'b0;
      cmd_write  <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      rsp_valid  <= 1'b0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_nxt;
      ready_en   <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      timer      <= timer_nxt;
      start      <= start_nxt;
      cmd_write  <= cmd_write_nxt;
      cmd_addr   <= cmd_addr_nxt;
      cmd_wdata  <= cmd_wdata_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_write  <= rsp_write_nxt;
      rsp_rdata  <= rsp_rdata_nxt;
      rsp_err    <= rsp_err_nxt;
      err_sticky <= err_sticky_nxt;
    end
  end

endmodule

// File: tb/tb_sched_request_issuer.sv
// Directed bench for sched_request_issuer: issue latency, in-order responses, FIFO full,
// timeout abort, response stall and asynchronous reset mid-command.
module tb_sched_request_issuer;

  localparam int WW = 512;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0, done = 1'b0, rsp_ready = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [WW-1:0] req_wdata = '0, ctl_rdata = '0;
  logic          req_ready, start, cmd_write, rsp_valid, rsp_write, rsp_err, err_sticky;
  logic [31:0]   cmd_addr;
  logic [WW-1:0] cmd_wdata, rsp_rdata;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int s0;

  logic [WW-1:0] pat_a5, pat_rd, pat6;

  sched_request_issuer dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .start(start), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .done(done), .ctl_rdata(ctl_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_sticky(err_sticky)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (reset && start) start_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [WW-1:0] d);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic fire_done(input logic [WW-1:0] d);
    ctl_rdata = d; done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    pat_a5 = {64{8'hA5}};
    pat_rd = {8{64'h0123_4567_89AB_CDEF}};
    pat6   = {8{64'hDEAD_BEEF_0BAD_F00D}};

    // reset state
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_start", start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rel_ready", req_ready, 1);

    // single write
    push(1'b1, 32'h0000_1040, pat_a5);
    chk("t2_no_start_yet", start, 0);
    tick();
    chk("t2_start", start, 1);
    chk("t2_cmd_write", cmd_write, 1);
    chk("t2_cmd_addr", cmd_addr, 32'h0000_1040);
    chk("t2_cmd_wdata", cmd_wdata, pat_a5);
    tick();
    chk("t2_start_pulse", start, 0);
    repeat (5) tick();
    chk("t2_no_rsp", rsp_valid, 0);
    fire_done(pat_rd);
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_write", rsp_write, 1);
    chk("t2_rsp_err", rsp_err, 0);
    chk("t2_rsp_rdata", rsp_rdata, 0);
    chk("t2_cmd_hold", cmd_addr, 32'h0000_1040);
    handshake();
    chk("t2_rsp_clear", rsp_valid, 0);
    chk("t2_one_start", start_cnt, 1);

    // single read
    push(1'b0, 32'h0000_2000, '0);
    tick();
    chk("t3_start", start, 1);
    chk("t3_cmd_write", cmd_write, 0);
    tick();
    fire_done(pat_rd);
    chk("t3_rsp_valid", rsp_valid, 1);
    chk("t3_rsp_write", rsp_write, 0);
    chk("t3_rsp_rdata", rsp_rdata, pat_rd);
    handshake();

    // nine pushes with done withheld: 8 queued + 1 in flight
    for (int i = 0; i < 9; i++) begin
      chk("t4_ready_before_push", req_ready, 1);
      push(1'b0, 32'h0000_3000 + 32'(i) * 32'h100, '0);
    end
    chk("t4_full_ready", req_ready, 0);
    chk("t4_head_addr", cmd_addr, 32'h0000_3000);
    for (int i = 0; i < 9; i++) begin
      if (i != 0) begin
        tick();
        chk("t4_start", start, 1);
        chk("t4_cmd_addr", cmd_addr, 32'h0000_3000 + 32'(i) * 32'h100);
        tick();
      end
      fire_done({8{64'(i + 16)}});
      chk("t4_rsp_valid", rsp_valid, 1);
      chk("t4_rsp_rdata", rsp_rdata, {8{64'(i + 16)}});
      handshake();
    end
    chk("t4_no_timeout", err_sticky, 0);

    // timeout, then next queued request still issues
    push(1'b0, 32'h0000_5000, '0);
    push(1'b1, 32'h0000_6000, pat_a5);
    chk("t5_start_a", start, 1);
    chk("t5_addr_a", cmd_addr, 32'h0000_5000);
    tick();
    repeat (254) tick();
    chk("t5_not_yet", rsp_valid, 0);
    tick();
    chk("t5_rsp_valid", rsp_valid, 1);
    chk("t5_rsp_err", rsp_err, 1);
    chk("t5_err_sticky", err_sticky, 1);
    chk("t5_rsp_rdata", rsp_rdata, 0);
    handshake();
    tick();
    chk("t5_start_b", start, 1);
    chk("t5_addr_b", cmd_addr, 32'h0000_6000);
    chk("t5_write_b", cmd_write, 1);
    tick();
    fire_done(pat_rd);
    chk("t5_b_err", rsp_err, 0);
    chk("t5_b_write", rsp_write, 1);
    chk("t5_sticky_held", err_sticky, 1);
    handshake();

    // done + push together with FIFO at DEPTH-1, response stalled
    for (int i = 0; i < 8; i++) push(1'b0, 32'h0000_7000 + 32'(i) * 32'h10, '0);
    chk("t6_ready_fullm1", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_7080;
    fire_done(pat6);
    req_valid = 1'b0;
    chk("t6_rsp_valid", rsp_valid, 1);
    chk("t6_rsp_rdata", rsp_rdata, pat6);
    chk("t6_full", req_ready, 0);
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_hold_valid", rsp_valid, 1);
      chk("t6_hold_rdata", rsp_rdata, pat6);
    end
    chk("t6_no_start", start_cnt, s0);
    handshake();
    chk("t6_rsp_clear", rsp_valid, 0);
    chk("t6_start_gap", start, 0);
    tick();
    chk("t6_start", start, 1);
    chk("t6_addr", cmd_addr, 32'h0000_7010);
    tick();

    // async reset mid-WAIT, late done ignored
    #2;
    reset = 1'b0;
    #1;
    chk("t1_ready", req_ready, 0);
    chk("t1_start", start, 0);
    chk("t1_cmd_addr", cmd_addr, 0);
    chk("t1_rsp_valid", rsp_valid, 0);
    chk("t1_err_sticky", err_sticky, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("t1_ready_rel", req_ready, 1);
    s0 = start_cnt;
    fire_done(pat6);
    chk("t1_late_done", rsp_valid, 0);
    tick();
    chk("t1_fifo_flushed", start_cnt, s0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
